// File: rtl/regbank_seq.sv
// Multi-cycle READ/EXEC/WRITE command sequencer for a 4-entry register bank.
// Optional saturating ADD/SUB when REGBANK_SEQ_SAT_EN is defined.
module regbank_seq #(
  parameter int Size = 8,
  parameter int NREG = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_dst,
  input  logic [$clog2(NREG)-1:0] cmd_src1,
  input  logic [$clog2(NREG)-1:0] cmd_src2,
  input  logic [Size-1:0]         cmd_imm,
  output logic [$clog2(NREG)-1:0] rb_a1,
  output logic [$clog2(NREG)-1:0] rb_a2,
  output logic [Size-1:0]         rb_wd,
  output logic                    rb_we,
  input  logic [Size-1:0]         rb_rd1,
  input  logic [Size-1:0]         rb_rd2,
  output logic                    done,
  output logic [Size-1:0]         result,
  output logic                    flag_z,
  output logic                    flag_c
);

  localparam int AW = $clog2(NREG);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_acc;

  logic [2:0]      r_op;
  logic [AW-1:0]   r_dst;
  logic [Size-1:0] r_imm;
  logic [Size-1:0] r_opa;
  logic [Size-1:0] r_opb;
  logic [Size-1:0] r_result;
  logic            r_z;
  logic            r_c;
  logic            r_ready;
  logic            r_we;
  logic            r_done;
  logic [AW-1:0]   r_a1;
  logic [AW-1:0]   r_a2;

  logic [Size:0]   w_sum;
  logic [Size:0]   w_dif;
  logic [Size-1:0] w_res;
  logic            w_z;
  logic            w_c;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_acc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_ready) begin
          w_acc  = 1'b1;
          w_next = S_READ;
        end
      end
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sum = {1'b0, r_opa} + {1'b0, r_opb};
    w_dif = {1'b0, r_opa} - {1'b0, r_opb};
    w_res = r_result;
    w_c   = 1'b0;
    unique case (r_op)
      OP_NOP: w_res = r_result;
      OP_LDI: w_res = r_imm;
      OP_MOV: w_res = r_opa;
      OP_ADD: begin
        w_res = w_sum[Size-1:0];
        w_c   = w_sum[Size];
`ifdef REGBANK_SEQ_SAT_EN
        if (w_sum[Size]) w_res = '1;
`endif
      end
      OP_SUB: begin
        w_res = w_dif[Size-1:0];
        w_c   = w_dif[Size];
`ifdef REGBANK_SEQ_SAT_EN
        if (w_dif[Size]) w_res = '0;
`endif
      end
      OP_AND: w_res = r_opa & r_opb;
      OP_OR:  w_res = r_opa | r_opb;
      OP_XOR: w_res = r_opa ^ r_opb;
      default: w_res = r_result;
    endcase
    w_z = (w_res == '0);
  end

  // Bank-side outputs are registered off the next state so they are glitch-free.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ready  <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_a1     <= '0;
      r_a2     <= '0;
      r_op     <= '0;
      r_dst    <= '0;
      r_imm    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_a1    <= '0;
      r_a2    <= '0;
      if (w_acc) begin
        r_op  <= cmd_op;
        r_dst <= cmd_dst;
        r_imm <= cmd_imm;
        r_a1  <= cmd_src1;
        r_a2  <= cmd_src2;
      end
      if (r_state == S_READ) begin
        r_opa <= rb_rd1;
        r_opb <= rb_rd2;
      end
      if (r_state == S_EXEC) begin
        r_a1   <= r_dst;
        r_we   <= (r_op != OP_NOP);
        r_done <= 1'b1;
        if (r_op != OP_NOP) begin
          r_result <= w_res;
          r_z      <= w_z;
          r_c      <= w_c;
        end
      end
    end
  end

  assign cmd_ready = r_ready;
  assign rb_a1     = r_a1;
  assign rb_a2     = r_a2;
  assign rb_wd     = r_result;
  assign rb_we     = r_we;
  assign done      = r_done;
  assign result    = r_result;
  assign flag_z    = r_z;
  assign flag_c    = r_c;

endmodule

// File: tb/tb_regbank_seq.sv
// Directed bench for regbank_seq with a behavioural 4-entry bank attached.
module tb_regbank_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src1;
  logic [1:0] cmd_src2;
  logic [7:0] cmd_imm;
  logic [1:0] rb_a1;
  logic [1:0] rb_a2;
  logic [7:0] rb_wd;
  logic       rb_we;
  logic [7:0] rb_rd1;
  logic [7:0] rb_rd2;
  logic       done;
  logic [7:0] result;
  logic       flag_z;
  logic       flag_c;

  logic [7:0] bank [4];
  int         n_chk = 0;
  int         n_fail = 0;
  int         we_cnt = 0;

  always #5 clk = ~clk;

  regbank_seq #(.Size(8), .NREG(4)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
    .cmd_imm(cmd_imm),
    .rb_a1(rb_a1), .rb_a2(rb_a2),
    .rb_wd(rb_wd), .rb_we(rb_we),
    .rb_rd1(rb_rd1), .rb_rd2(rb_rd2),
    .done(done), .result(result),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  assign rb_rd1 = bank[rb_a1];
  assign rb_rd2 = bank[rb_a2];

  always @(posedge clk) begin
    if (rb_we) begin
      bank[rb_a1] <= rb_wd;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] d,
                      input logic [1:0] s1, input logic [1:0] s2,
                      input logic [7:0] imm);
    int k;
    cmd_op    = op;
    cmd_dst   = d;
    cmd_src1  = s1;
    cmd_src2  = s2;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) chk("accept_timeout", k, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic tail(input logic [1:0] s1, input logic [1:0] s2,
                      input logic [1:0] d, input logic [7:0] res,
                      input logic z, input logic c, input logic we);
    chk("read_a1", rb_a1, s1);
    chk("read_a2", rb_a2, s2);
    chk("read_we", rb_we, 0);
    @(posedge clk); #1;
    chk("exec_done", done, 0);
    chk("exec_a1", rb_a1, 0);
    @(posedge clk); #1;
    chk("wr_done", done, 1);
    chk("wr_we", rb_we, we);
    chk("wr_a1", rb_a1, d);
    chk("wr_wd", rb_wd, res);
    chk("result", result, res);
    chk("flag_z", flag_z, z);
    chk("flag_c", flag_c, c);
    chk("wr_ready", cmd_ready, 0);
    @(posedge clk); #1;
    chk("idle_ready", cmd_ready, 1);
    chk("idle_done", done, 0);
    chk("idle_we", rb_we, 0);
  endtask

  task automatic run(input logic [2:0] op, input logic [1:0] d,
                     input logic [1:0] s1, input logic [1:0] s2,
                     input logic [7:0] imm, input logic [7:0] res,
                     input logic z, input logic c, input logic we);
    send(op, d, s1, s2, imm);
    tail(s1, s2, d, res, z, c, we);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  k;
    logic rdy;
    clr = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_dst = '0; cmd_src1 = '0;
    cmd_src2 = '0; cmd_imm = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_we", rb_we, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_z, flag_c}, 0);
    #2 clr = 1'b0;
    @(posedge clk); #1;
    chk("rel_ready", cmd_ready, 1);

    // Abort in the middle of READ
    send(3'b001, 2'd3, 2'd1, 2'd2, 8'hAA);
    chk("abort_read_a1", rb_a1, 1);
    #2 clr = 1'b1;
    #1;
    chk("abort_ready", cmd_ready, 0);
    chk("abort_a1", rb_a1, 0);
    chk("abort_we", rb_we, 0);
    chk("abort_done", done, 0);
    @(posedge clk);
    #3 clr = 1'b0;
    @(posedge clk); #1;
    chk("abort_rel_ready", cmd_ready, 1);
    chk("abort_no_write", we_cnt, 0);

    run(3'b001, 2'd2, 2'd0, 2'd0, 8'h5A, 8'h5A, 0, 0, 1);
    chk("bank_r2", bank[2], 8'h5A);

    run(3'b001, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 0, 0, 1);
    run(3'b001, 2'd1, 2'd0, 2'd0, 8'h20, 8'h20, 0, 0, 1);
`ifdef REGBANK_SEQ_SAT_EN
    run(3'b011, 2'd0, 2'd0, 2'd1, 8'h00, 8'hFF, 0, 1, 1);
    chk("bank_r0_add", bank[0], 8'hFF);
`else
    run(3'b011, 2'd0, 2'd0, 2'd1, 8'h00, 8'h10, 0, 1, 1);
    chk("bank_r0_add", bank[0], 8'h10);
`endif

    run(3'b001, 2'd3, 2'd0, 2'd0, 8'h05, 8'h05, 0, 0, 1);
    run(3'b100, 2'd3, 2'd3, 2'd3, 8'h00, 8'h00, 1, 0, 1);
    chk("bank_r3_sub", bank[3], 8'h00);

    run(3'b001, 2'd0, 2'd0, 2'd0, 8'h10, 8'h10, 0, 0, 1);
`ifdef REGBANK_SEQ_SAT_EN
    run(3'b100, 2'd3, 2'd0, 2'd1, 8'h00, 8'h00, 1, 1, 1);
`else
    run(3'b100, 2'd3, 2'd0, 2'd1, 8'h00, 8'hF0, 0, 1, 1);
`endif
    run(3'b111, 2'd3, 2'd2, 2'd1, 8'h00, 8'h7A, 0, 0, 1);
    run(3'b101, 2'd3, 2'd2, 2'd0, 8'h00, 8'h10, 0, 0, 1);
    run(3'b110, 2'd3, 2'd2, 2'd1, 8'h00, 8'h7A, 0, 0, 1);
    chk("bank_r3_or", bank[3], 8'h7A);

    // NOP keeps result/flags from the OR and writes nothing
    k = we_cnt;
    run(3'b000, 2'd0, 2'd1, 2'd1, 8'h00, 8'h7A, 0, 0, 0);
    chk("nop_no_write", we_cnt, k);
    chk("nop_bank_r0", bank[0], 8'h10);

    // Second command held valid while the first is in flight
    cmd_op = 3'b001; cmd_dst = 2'd2; cmd_src1 = 2'd0;
    cmd_src2 = 2'd0; cmd_imm = 8'h33;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    cmd_op = 3'b010; cmd_dst = 2'd1; cmd_src1 = 2'd2;
    cmd_src2 = 2'd3; cmd_imm = 8'hEE;
    k = 0;
    do begin
      rdy = cmd_ready;
      @(posedge clk); #1;
      k++;
    end while (!rdy && k < 10);
    cmd_valid = 1'b0;
    chk("stall_cycles", k, 4);
    chk("stall_bank_r2", bank[2], 8'h33);
    tail(2'd2, 2'd3, 2'd1, 8'h33, 0, 0, 1);
    chk("mov_bank_r1", bank[1], 8'h33);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
